br_4_bank_seq: RTL

Upstream feeder for the 4-bit 4:1 output multiplexer. It collects four 4-bit nibbles from a valid/ready stream into a shadow bank and commits them atomically to the four parallel operand outputs `A0..A3`. It also generates the 2-bit select `s`, either registered from a host value or auto-scanned round-robin at a programmable rate. The downstream mux sees only complete frames, never a partially written bank.

---
 rtl/br_4_bank_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/br_4_bank_seq.sv
`default_nettype none
// ============================================================================
// Module      : br_4_bank_seq
// Description : Collects four 4-bit nibbles from a valid/ready stream into a
//               shadow bank and commits them atomically to A0..A3. Generates
//               the 2-bit mux select, either from a host value or by
//               round-robin auto-scan at a programmable rate.
// Revision    : 1.0 - initial release
// ============================================================================
module br_4_bank_seq #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       frame_abort,
    input  logic       scan_en,
    input  logic [1:0] sel_in,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [1:0] s,
    output logic       frame_done,
    output logic       scan_tick
);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    // Last divider value before the select steps.
    localparam logic [7:0] C_DIV_LAST = 8'(SCAN_DIV - 1);

    state_t     state_q, state_d;
    logic [1:0] wp_q, wp_d;
    // Only three shadow slots: the fourth beat goes straight to A3.
    logic [3:0] sh_q [0:2];
    logic [3:0] sh_d [0:2];
    logic [3:0] op_q [0:3];
    logic [3:0] op_d [0:3];
    logic       in_ready_q, in_ready_d;
    logic       frame_done_q, frame_done_d;
    logic [1:0] s_q, s_d;
    logic [7:0] div_q, div_d;

    logic       w_xfer;
    logic       w_scan_wrap;

    assign w_xfer      = in_valid && in_ready_q;
    assign w_scan_wrap = scan_en && (div_q == C_DIV_LAST);

    // Frame collection: fill the shadow bank, commit on the fourth beat.
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        sh_d         = sh_q;
        op_d         = op_q;
        in_ready_d   = in_ready_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_FILL: begin
                in_ready_d = 1'b1;
                if (frame_abort) begin
                    // Partial frame is dropped together with any same-cycle beat.
                    wp_d = 2'd0;
                end else if (w_xfer) begin
                    case (wp_q)
                        2'd0: sh_d[0] = in_data;
                        2'd1: sh_d[1] = in_data;
                        2'd2: sh_d[2] = in_data;
                        default: begin
                            op_d[0]      = sh_q[0];
                            op_d[1]      = sh_q[1];
                            op_d[2]      = sh_q[2];
                            op_d[3]      = in_data;
                            state_d      = ST_COMMIT;
                            in_ready_d   = 1'b0;
                            frame_done_d = 1'b1;
                        end
                    endcase
                    wp_d = wp_q + 2'd1;
                end
            end
            ST_COMMIT: begin
                state_d    = ST_FILL;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_FILL;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // Select generation: host value, or round-robin stepping every SCAN_DIV cycles.
    always_comb begin
        s_d   = s_q;
        div_d = div_q;
        if (!scan_en) begin
            s_d   = sel_in;
            div_d = 8'd0;
        end else if (w_scan_wrap) begin
            s_d   = s_q + 2'd1;
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // State registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            wp_q         <= 2'd0;
            sh_q[0]      <= 4'd0;
            sh_q[1]      <= 4'd0;
            sh_q[2]      <= 4'd0;
            op_q[0]      <= 4'd0;
            op_q[1]      <= 4'd0;
            op_q[2]      <= 4'd0;
            op_q[3]      <= 4'd0;
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            s_q          <= 2'd0;
            div_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            sh_q         <= sh_d;
            op_q         <= op_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            s_q          <= s_d;
            div_q        <= div_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;
    assign A0         = op_q[0];
    assign A1         = op_q[1];
    assign A2         = op_q[2];
    assign A3         = op_q[3];
    assign s          = s_q;
    assign scan_tick  = w_scan_wrap;

endmodule
`default_nettype wire
